// File: rtl/axi_tensor_rd.sv
// axi_tensor_rd -- AXI4 single-burst read master that loads one 8x8 PE
// operand/accumulator tile from DRAM into the PE regfiles.
//
// Beat k lands on PE k%64 (row = pe[5:3], col = pe[2:0]) in wave k/64, the
// same ordering the tensor write-back path uses.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   rd_enb                   start pulse (only honoured in IDLE)
//   mixed, addr_type         precision mode, latched at start
//   rd_base                  burst start address, latched at start
//   axi_ar*                  AXI read-address channel (single INCR burst)
//   axi_r*                   AXI read-data channel
//   rf_we/row/col/data/be    regfile write port, one write per accepted beat
//   rd_busy, rd_done, rd_err status (busy level, done pulse, sticky error)
//
// Modes
//   normal  : 256 beats, each beat fills one 32-bit lane (lane = wave).
//   special : addr_type.datatype == FP16 with mixed == 0; 128 beats, each
//             beat splits into two FP16 halves placed at the bottom of lanes
//             0/1 (wave 0) or lanes 2/3 (wave 1).
//
// Configuration
//   AXI_RD_ERRCHK_EN  when defined, rresp and rlast are checked and reported
//                     through rd_err; an early rlast terminates the burst.
//                     When undefined, rresp/rlast are ignored and rd_err is 0.

package axi_tensor_rd_pkg;
  typedef enum logic [1:0] {
    DT_INT8 = 2'd0,
    DT_FP16 = 2'd1,
    DT_BF16 = 2'd2,
    DT_FP32 = 2'd3
  } datatype_e;

  typedef struct packed {
    datatype_e  datatype;
    logic [5:0] tile;
  } addrgen_t;
endpackage

// Per-lane data placement: one instance per 32-bit lane of rf_data.
module axi_tensor_rd_lane #(
  parameter int LANE = 0
) (
  input  logic        special,
  input  logic [1:0]  wave,
  input  logic [31:0] rdata,
  output logic [31:0] data,
  output logic [3:0]  be
);
  localparam logic [1:0] LN = 2'(LANE);

  always_comb begin
    data = '0;
    be   = '0;
    if (special) begin
      // lanes 0/1 belong to wave 0, lanes 2/3 to wave 1; odd lanes take the
      // upper FP16 half of the beat
      if (wave[0] == LN[1]) begin
        data = {16'h0, LN[0] ? rdata[31:16] : rdata[15:0]};
        be   = 4'h3;
      end
    end else if (wave == LN) begin
      data = rdata;
      be   = 4'hF;
    end
  end
endmodule

module axi_tensor_rd
  import axi_tensor_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_enb,
  input  logic                  mixed,
  input  addrgen_t              addr_type,
  input  logic [ADDR_WIDTH-1:0] rd_base,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  input  logic [31:0]           axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rlast,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  output logic                  rf_we,
  output logic [2:0]            rf_row,
  output logic [2:0]            rf_col,
  output logic [127:0]          rf_data,
  output logic [15:0]           rf_be,
  output logic                  rd_busy,
  output logic                  rd_done,
  output logic                  rd_err
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST_NORM = BW'(255);
  localparam logic [BW-1:0] LAST_SPEC = BW'(127);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA} state_e;

  state_e state_q, state_d;
  logic   start;
  logic   special_q;
  logic   ar_hs, r_hs, last_beat, burst_end, beat_err;

  logic [BW-1:0] beat_cnt;
  logic [5:0]    pe_cnt;
  logic [1:0]    wave_cnt;

  logic [NUM_LANES-1:0][31:0] lane_data;
  logic [NUM_LANES-1:0][3:0]  lane_be;

  assign axi_arsize  = 3'b010;
  assign axi_arburst = 2'b01;
  assign axi_rready  = (state_q == RD_DATA);
  assign rd_busy     = (state_q != IDLE);

  assign ar_hs     = axi_arvalid & axi_arready;
  assign r_hs      = axi_rvalid & axi_rready;
  assign last_beat = (beat_cnt == (special_q ? LAST_SPEC : LAST_NORM));

`ifdef AXI_RD_ERRCHK_EN
  // rlast on a non-final beat ends the burst early; rlast missing on the
  // final beat, or any non-OKAY response, only flags the error
  assign burst_end = r_hs & (last_beat | axi_rlast);
  assign beat_err  = r_hs & ((axi_rresp != 2'b00) | (axi_rlast ^ last_beat));
`else
  assign burst_end = r_hs & last_beat;
  assign beat_err  = 1'b0;
  logic unused_rsp;
  assign unused_rsp = ^{axi_rresp, axi_rlast};
`endif

  logic unused_tile;
  assign unused_tile = ^addr_type.tile;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_enb) begin
          state_d = RD_ADDR;
          start   = 1'b1;
        end
      end
      RD_ADDR: if (ar_hs)     state_d = RD_DATA;
      RD_DATA: if (burst_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------- AR channel
  // arvalid is registered so it rises the cycle after the accepted rd_enb;
  // araddr/arlen are only loaded at start, so they are stable while valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      axi_arvalid <= 1'b0;
      axi_araddr  <= '0;
      axi_arlen   <= '0;
      special_q   <= 1'b0;
    end else if (start) begin
      axi_arvalid <= 1'b1;
      axi_araddr  <= rd_base;
      special_q   <= (addr_type.datatype == DT_FP16) && !mixed;
      axi_arlen   <= ((addr_type.datatype == DT_FP16) && !mixed) ? 8'd127 : 8'd255;
    end else if (ar_hs) begin
      axi_arvalid <= 1'b0;
    end
  end

  // ------------------------------------------------------------ counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      pe_cnt   <= '0;
      wave_cnt <= '0;
    end else if (start) begin
      beat_cnt <= '0;
      pe_cnt   <= '0;
      wave_cnt <= '0;
    end else if (r_hs) begin
      beat_cnt <= beat_cnt + 1'b1;
      pe_cnt   <= pe_cnt + 1'b1;
      if (pe_cnt == 6'd63) wave_cnt <= wave_cnt + 1'b1;
    end
  end

  // -------------------------------------------------------- lane placement
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    axi_tensor_rd_lane #(.LANE(g)) u_lane (
      .special (special_q),
      .wave    (wave_cnt),
      .rdata   (axi_rdata),
      .data    (lane_data[g]),
      .be      (lane_be[g])
    );
  end

  // ---------------------------------------------------- regfile write port
  // Write fields are zeroed on idle cycles so rf_data/rf_be never carry a
  // stale beat alongside rf_we=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we   <= 1'b0;
      rf_row  <= '0;
      rf_col  <= '0;
      rf_data <= '0;
      rf_be   <= '0;
    end else begin
      rf_we <= r_hs;
      if (r_hs) begin
        rf_row  <= pe_cnt[5:3];
        rf_col  <= pe_cnt[2:0];
        rf_data <= lane_data;
        rf_be   <= lane_be;
      end else begin
        rf_row  <= '0;
        rf_col  <= '0;
        rf_data <= '0;
        rf_be   <= '0;
      end
    end
  end

  // --------------------------------------------------------------- status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_done <= 1'b0;
      rd_err  <= 1'b0;
    end else begin
      rd_done <= burst_end;
      if (start)         rd_err <= 1'b0;
      else if (beat_err) rd_err <= 1'b1;
    end
  end
endmodule
